framebuffer_window_reader: RTL and testbench
============================================

Name: framebuffer_window_reader

Overview:
- Read-side initiator for the Framebuffer read port.
- On a start pulse, it walks a raster of window centres across the 4-bpp 640x480 image.
- For each centre it issues a read and waits for data_ready, then captures the 100-bit 5x5 pixel chunk.
- It hands each chunk, tagged with its centre coordinates, to the downstream convolution stage over a valid/ready stream.

Parameters:
- WIDTH, 640, image width in pixels.
- HEIGHT, 480, image height in pixels.
- STRIDE, 1, step between successive window centres in x and in y.
- TIMEOUT_CYCLES, 1024, maximum number of cycles read may be held without data_ready.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  one-cycle pulse that begins a frame scan; ignored while busy.
- busy  out  1  high from start acceptance until done or abort.
- done  out  1  one-cycle pulse after the last window is accepted downstream.
- timeout_err  out  1  sticky error flag; cleared by the next accepted start.
- x_pos  out  10  framebuffer read x coordinate (window centre).
- y_pos  out  10  framebuffer read y coordinate.
- read  out  1  framebuffer read request.
- data_chunk  in  100  framebuffer 5x5 window, 25 pixels x 4 bits.
- data_ready  in  1  framebuffer response strobe; data_chunk is valid while it is high.
- win_data  out  100  captured window.
- win_x  out  10  centre x of win_data.
- win_y  out  10  centre y of win_data.
- win_valid  out  1  stream valid.
- win_ready  in  1  stream ready.
- win_last  out  1  marks the final window of the frame; qualified by win_valid.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE.
- Reset mid-scan: the scan is abandoned immediately; read drops asynchronously; no done pulse.
- States are IDLE, REQ, PRESENT, RELEASE, FINISH.
- IDLE:
  - start=1 loads x=0, y=0, sets busy=1, clears timeout_err, and moves to REQ.
  - read rises on the edge after start is sampled.
- REQ:
  - read=1; x_pos and y_pos are stable throughout the request.
  - When data_ready is sampled high: data_chunk is registered into win_data, x_pos/y_pos are copied to win_x/win_y, read goes to 0 on that same edge, and the FSM moves to PRESENT.
  - Latency from read rising to win_valid is the framebuffer latency plus 1 cycle.
- Timeout in REQ:
  - A cycle counter runs while in REQ.
  - When it reaches TIMEOUT_CYCLES: timeout_err=1, read=0, busy=0, state goes to IDLE, and no done pulse is issued.
- PRESENT:
  - win_valid=1; win_data, win_x, win_y and win_last are held stable until the handshake completes.
  - On win_valid && win_ready, coordinates advance as follows:
    - x += STRIDE.
    - If x+STRIDE > WIDTH-1: x=0, y += STRIDE.
    - If that also gives y+STRIDE > HEIGHT-1, the frame is complete.
  - If the frame is not complete, go to RELEASE; if it is, go to FINISH.
- win_last=1 exactly when the held window is the last one, i.e. the coordinates are (last x, last y) under the stride rule.
- RELEASE:
  - Wait until data_ready is sampled 0 (minimum 1 cycle), then go to REQ.
  - This guarantees a stale data_ready is never captured twice.
- FINISH:
  - done=1 for one cycle, busy=0, go to IDLE.
- Output coordinates stay at their last value when idle; they are never driven to Z.
- win_ready held low stalls indefinitely in PRESENT; no timeout applies.
- start while busy has no effect.
- data_ready outside REQ is ignored.
- Window count per frame = ceil(WIDTH/STRIDE) x ceil(HEIGHT/STRIDE), giving 307200 at the defaults.
- Coordinate arithmetic is performed in 11 bits so the comparisons cannot overflow; the ports carry 10 bits.

Decomposition:
- Shared package fb_pkg holds:
  - FB_WIDTH=640, FB_HEIGHT=480, COORD_BITS=10.
  - PIX_BITS=4, WIN_DIM=5, CHUNK_BITS=WIN_DIM*WIN_DIM*PIX_BITS=100.
  - typedef coord_t (10 bits) and typedef chunk_t (100 bits).
  - The reader state enum.
- One sub-module, fb_coord_scanner, owns the x/y stride counters.
  - Inputs: load, step.
  - Outputs: x, y, is_last.
  - It is reused by the write-side packer.

Test Plan:
- Single window: WIDTH=8, HEIGHT=4, STRIDE=8; framebuffer model returns data_ready 3 cycles after read with chunk 100'h1234 -> exactly one window with win_x=0, win_y=0, win_data=100'h1234, win_last=1; done pulses 1 cycle after acceptance; busy then 0.
- Raster order: WIDTH=8, HEIGHT=4, STRIDE=2, model returns chunk={x,y} -> 8 windows in order (0,0),(2,0),(4,0),(6,0),(0,2),(2,2),(4,2),(6,2); win_last only on (6,2).
- Backpressure: win_ready low for 10 cycles in PRESENT -> win_valid and win_data stable, read stays 0, no coordinate advance; release -> next read issued 2 cycles later.
- Sticky data_ready: model holds data_ready high for 4 cycles -> a single capture; the next read is issued only after data_ready is 0.
- Timeout: TIMEOUT_CYCLES=16, model never responds -> read falls after 16 cycles in REQ, timeout_err=1, busy=0, no done; a new start clears timeout_err.
- Reset mid-scan: reset driven low during REQ -> read, busy and win_valid are 0 immediately; after release, start rescans from (0,0).

Source files
------------

// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, pixel-chunk types and the window reader state encoding.
package fb_pkg;

   localparam int FB_WIDTH   = 640;
   localparam int FB_HEIGHT  = 480;
   localparam int COORD_BITS = 10;
   localparam int PIX_BITS   = 4;
   localparam int WIN_DIM    = 5;
   localparam int CHUNK_BITS = WIN_DIM * WIN_DIM * PIX_BITS;

   // One extra bit so that coordinate + stride never wraps before it is compared.
   localparam int ARITH_BITS = COORD_BITS + 1;

   typedef logic [COORD_BITS-1:0] coord_t;
   typedef logic [CHUNK_BITS-1:0] chunk_t;
   typedef logic [ARITH_BITS-1:0] coord_ext_t;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      PRESENT,
      RELEASE,
      FINISH
   } reader_state_t;

   function automatic coord_ext_t extend_coord(input coord_t c);
      return {1'b0, c};
   endfunction

endpackage

// File: rtl/fb_coord_scanner.sv
// Raster x/y counter stepping by STRIDE; shared by the framebuffer read and write sides.
module fb_coord_scanner
   import fb_pkg::*;
#(
   parameter int WIDTH  = FB_WIDTH,
   parameter int HEIGHT = FB_HEIGHT,
   parameter int STRIDE = 1
)
(
   input  logic   clk,
   input  logic   reset,
   input  logic   load,
   input  logic   step,
   output coord_t x,
   output coord_t y,
   output logic   is_last
);

   localparam coord_ext_t STEP  = coord_ext_t'(STRIDE);
   localparam coord_ext_t X_MAX = coord_ext_t'(WIDTH - 1);
   localparam coord_ext_t Y_MAX = coord_ext_t'(HEIGHT - 1);

   coord_ext_t x_next;
   coord_ext_t y_next;
   logic       x_wrap;
   logic       y_wrap;

   always_comb begin
      x_next = extend_coord(x) + STEP;
      y_next = extend_coord(y) + STEP;
      x_wrap = (x_next > X_MAX);
      y_wrap = (y_next > Y_MAX);
   end

   assign is_last = x_wrap && y_wrap;

   // The final position is held rather than stepped, so the coordinates rest there when idle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         x <= '0;
         y <= '0;
      end else if (load) begin
         x <= '0;
         y <= '0;
      end else if (step && !is_last) begin
         if (x_wrap) begin
            x <= '0;
            y <= y_next[COORD_BITS-1:0];
         end else begin
            x <= x_next[COORD_BITS-1:0];
         end
      end
   end

endmodule

// File: rtl/framebuffer_window_reader.sv
// Walks window centres over the framebuffer, fetches each 5x5 chunk and streams it downstream.
module framebuffer_window_reader
   import fb_pkg::*;
#(
   parameter int WIDTH          = FB_WIDTH,
   parameter int HEIGHT         = FB_HEIGHT,
   parameter int STRIDE         = 1,
   parameter int TIMEOUT_CYCLES = 1024
)
(
   input  logic   clk,
   input  logic   reset,
   input  logic   start,
   output logic   busy,
   output logic   done,
   output logic   timeout_err,
   output coord_t x_pos,
   output coord_t y_pos,
   output logic   read,
   input  chunk_t data_chunk,
   input  logic   data_ready,
   output chunk_t win_data,
   output coord_t win_x,
   output coord_t win_y,
   output logic   win_valid,
   input  logic   win_ready,
   output logic   win_last
);

   localparam int TO_BITS = $clog2(TIMEOUT_CYCLES + 1);

   reader_state_t        state;
   reader_state_t        state_next;
   logic [TO_BITS-1:0]   wait_count;
   logic                 scan_last;
   logic                 accept;
   logic                 capture;
   logic                 handshake;
   logic                 timed_out;

   assign accept    = (state == IDLE) && start;
   assign capture   = (state == REQ) && data_ready;
   assign handshake = (state == PRESENT) && win_ready;
   assign timed_out = (state == REQ) && !data_ready
                      && (wait_count == TO_BITS'(TIMEOUT_CYCLES - 1));

   fb_coord_scanner #(
      .WIDTH  (WIDTH),
      .HEIGHT (HEIGHT),
      .STRIDE (STRIDE)
   ) scanner (
      .clk     (clk),
      .reset   (reset),
      .load    (accept),
      .step    (handshake),
      .x       (x_pos),
      .y       (y_pos),
      .is_last (scan_last)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (start) state_next = REQ;
         REQ: begin
            if (data_ready) begin
               state_next = PRESENT;
            end else if (timed_out) begin
               state_next = IDLE;
            end
         end
         PRESENT: if (win_ready) state_next = scan_last ? FINISH : RELEASE;
         // Wait out any response strobe still high from the previous capture.
         RELEASE: if (!data_ready) state_next = REQ;
         FINISH:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      read      = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      win_valid = 1'b0;
      unique case (state)
         REQ: begin
            read = 1'b1;
            busy = 1'b1;
         end
         PRESENT: begin
            win_valid = 1'b1;
            busy      = 1'b1;
         end
         RELEASE: busy = 1'b1;
         FINISH:  done = 1'b1;
         default: ;
      endcase
   end

   assign win_last = win_valid && scan_last;

   // Counts cycles spent holding read; restarts from zero on every entry into REQ.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wait_count <= '0;
      end else if (state != REQ) begin
         wait_count <= '0;
      end else begin
         wait_count <= wait_count + TO_BITS'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         timeout_err <= 1'b0;
      end else if (accept) begin
         timeout_err <= 1'b0;
      end else if (timed_out) begin
         timeout_err <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         win_data <= '0;
         win_x    <= '0;
         win_y    <= '0;
      end else if (capture) begin
         win_data <= data_chunk;
         win_x    <= x_pos;
         win_y    <= y_pos;
      end
   end

endmodule

// File: tb/tb_framebuffer_window_reader.sv
// Self-checking bench: a latency/hold-configurable framebuffer model feeds the reader, and a raster reference list checks the stream.
module tb_framebuffer_window_reader;
   import fb_pkg::*;

   localparam int W = 8;
   localparam int H = 4;
   localparam int S = 2;
   localparam int T = 16;

   typedef logic [127:0] val_t;

   logic   clk;
   logic   reset;
   logic   start;
   logic   busy;
   logic   done;
   logic   timeout_err;
   coord_t x_pos;
   coord_t y_pos;
   logic   read;
   chunk_t data_chunk;
   logic   data_ready;
   chunk_t win_data;
   coord_t win_x;
   coord_t win_y;
   logic   win_valid;
   logic   win_ready;
   logic   win_last;

   int     compared   = 0;
   int     mismatched = 0;

   bit     fbEnable   = 1'b1;
   int     fbLatency  = 0;
   int     fbHold     = 1;
   chunk_t salt       = '0;

   framebuffer_window_reader #(
      .WIDTH          (W),
      .HEIGHT         (H),
      .STRIDE         (S),
      .TIMEOUT_CYCLES (T)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .busy        (busy),
      .done        (done),
      .timeout_err (timeout_err),
      .x_pos       (x_pos),
      .y_pos       (y_pos),
      .read        (read),
      .data_chunk  (data_chunk),
      .data_ready  (data_ready),
      .win_data    (win_data),
      .win_x       (win_x),
      .win_y       (win_y),
      .win_valid   (win_valid),
      .win_ready   (win_ready),
      .win_last    (win_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic chunk_t chunkFor(input coord_t x, input coord_t y);
      logic [19:0] xy;
      xy = {x, y};
      return {5{xy}} ^ salt;
   endfunction

   task automatic checkOutput(input string tag, input val_t observed, input val_t expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Framebuffer model: answers a held read after a latency, keeping data_ready up for fbHold cycles.
   initial begin
      int reqAge;
      int drLeft;
      int curLatency;
      reqAge     = 0;
      drLeft     = 0;
      curLatency = 1;
      data_ready = 1'b0;
      data_chunk = '0;
      forever begin
         @(posedge clk);
         #1;
         if (drLeft > 0) begin
            drLeft--;
            if (drLeft == 0) data_ready = 1'b0;
         end
         if (!reset || !read) begin
            reqAge = 0;
         end else if (fbEnable && !data_ready) begin
            if (reqAge == 0) curLatency = (fbLatency > 0) ? fbLatency : int'($urandom_range(1, 4));
            reqAge++;
            if (reqAge >= curLatency) begin
               data_ready = 1'b1;
               data_chunk = chunkFor(x_pos, y_pos);
               drLeft     = fbHold;
               reqAge     = 0;
            end
         end
      end
   end

   task automatic applyStimulus(input int readyPct, input bit stallFirst, input string name);
      int     expX[$];
      int     expY[$];
      int     idx;
      int     cycles;
      int     stallLeft;
      int     releaseCountdown;
      bit     stalled;
      bit     pendingRelease;
      bit     doneSeen;
      bit     expectDone;
      chunk_t expData;
      for (int yy = 0; yy < H; yy += S) begin
         for (int xx = 0; xx < W; xx += S) begin
            expX.push_back(xx);
            expY.push_back(yy);
         end
      end
      salt = chunk_t'({$urandom(), $urandom(), $urandom(), $urandom()});
      idx = 0; cycles = 0; stallLeft = 0; releaseCountdown = 0;
      stalled = 1'b0; pendingRelease = 1'b0; doneSeen = 1'b0; expectDone = 1'b0;

      @(negedge clk);
      start     = 1'b1;
      win_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      checkOutput({name, " busy after start"}, val_t'(busy), val_t'(1));
      checkOutput({name, " read after start"}, val_t'(read), val_t'(1));
      checkOutput({name, " timeout_err cleared"}, val_t'(timeout_err), val_t'(0));
      checkOutput({name, " x_pos origin"}, val_t'(x_pos), val_t'(0));
      checkOutput({name, " y_pos origin"}, val_t'(y_pos), val_t'(0));

      while (!doneSeen && cycles < 2000) begin
         start = (cycles == 5) ? 1'b1 : 1'b0;
         if (expectDone) begin
            checkOutput({name, " done after last accept"}, val_t'(done), val_t'(1));
            expectDone = 1'b0;
         end
         if (done) begin
            doneSeen = 1'b1;
            checkOutput({name, " window count"}, val_t'(idx), val_t'(expX.size()));
            checkOutput({name, " busy at done"}, val_t'(busy), val_t'(0));
         end
         if (releaseCountdown > 0) begin
            releaseCountdown--;
            if (releaseCountdown == 0)
               checkOutput({name, " read after stall release"}, val_t'(read), val_t'(1));
         end
         if (read && idx < expX.size()) begin
            checkOutput({name, " req x_pos"}, val_t'(x_pos), val_t'(expX[idx]));
            checkOutput({name, " req y_pos"}, val_t'(y_pos), val_t'(expY[idx]));
         end
         if (win_valid) begin
            checkOutput({name, " read low while presenting"}, val_t'(read), val_t'(0));
            if (idx < expX.size()) begin
               expData = chunkFor(coord_t'(expX[idx]), coord_t'(expY[idx]));
               checkOutput({name, " win_x"}, val_t'(win_x), val_t'(expX[idx]));
               checkOutput({name, " win_y"}, val_t'(win_y), val_t'(expY[idx]));
               checkOutput({name, " win_data"}, val_t'(win_data), val_t'(expData));
               checkOutput({name, " win_last"}, val_t'(win_last), val_t'(idx == expX.size() - 1));
               checkOutput({name, " x_pos held"}, val_t'(x_pos), val_t'(expX[idx]));
            end else begin
               checkOutput({name, " window beyond frame"}, val_t'(idx), val_t'(expX.size() - 1));
            end
         end

         if (win_valid && stallFirst && !stalled) begin
            stalled   = 1'b1;
            stallLeft = 10;
         end
         if (stallLeft > 0) begin
            win_ready = 1'b0;
            stallLeft--;
            if (stallLeft == 0) pendingRelease = 1'b1;
         end else if (pendingRelease) begin
            win_ready = 1'b1;
         end else begin
            win_ready = (int'($urandom_range(0, 99)) < readyPct);
         end
         if (win_valid && win_ready) begin
            idx++;
            if (idx == expX.size()) expectDone = 1'b1;
            if (pendingRelease) begin
               pendingRelease   = 1'b0;
               releaseCountdown = 2;
            end
         end

         @(negedge clk);
         cycles++;
      end
      start     = 1'b0;
      win_ready = 1'b0;
      checkOutput({name, " frame completed"}, val_t'(doneSeen), val_t'(1));
      @(negedge clk);
      checkOutput({name, " done single pulse"}, val_t'(done), val_t'(0));
      checkOutput({name, " idle busy"}, val_t'(busy), val_t'(0));
      checkOutput({name, " idle x_pos rests at last"}, val_t'(x_pos), val_t'(expX[expX.size() - 1]));
   endtask

   initial begin
      int n;
      int doneCount;
      reset     = 1'b0;
      start     = 1'b0;
      win_ready = 1'b0;

      repeat (2) @(negedge clk);
      checkOutput("reset busy", val_t'(busy), val_t'(0));
      checkOutput("reset done", val_t'(done), val_t'(0));
      checkOutput("reset read", val_t'(read), val_t'(0));
      checkOutput("reset win_valid", val_t'(win_valid), val_t'(0));
      checkOutput("reset win_last", val_t'(win_last), val_t'(0));
      checkOutput("reset timeout_err", val_t'(timeout_err), val_t'(0));
      checkOutput("reset win_data", val_t'(win_data), val_t'(0));
      checkOutput("reset x_pos", val_t'(x_pos), val_t'(0));
      reset = 1'b1;
      @(negedge clk);

      $display("[TB] frame with random latency, full throughput");
      applyStimulus(100, 1'b0, "frameA");

      $display("[TB] frame with initial 10-cycle stall and random backpressure");
      applyStimulus(50, 1'b1, "frameB");

      $display("[TB] frame with data_ready held for 4 cycles");
      fbLatency = 3;
      fbHold    = 4;
      applyStimulus(70, 1'b0, "frameC");
      fbLatency = 0;
      fbHold    = 1;

      $display("[TB] timeout with silent framebuffer");
      fbEnable = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start     = 1'b0;
      n         = 0;
      doneCount = 0;
      while (read === 1'b1 && n < 100) begin
         n++;
         if (done) doneCount++;
         @(negedge clk);
      end
      checkOutput("timeout read cycles", val_t'(n), val_t'(T));
      checkOutput("timeout err set", val_t'(timeout_err), val_t'(1));
      checkOutput("timeout busy", val_t'(busy), val_t'(0));
      repeat (5) begin
         if (done) doneCount++;
         @(negedge clk);
      end
      checkOutput("timeout no done", val_t'(doneCount), val_t'(0));
      checkOutput("timeout err sticky", val_t'(timeout_err), val_t'(1));
      fbEnable = 1'b1;
      applyStimulus(100, 1'b0, "frameD");

      $display("[TB] reset asserted mid-scan");
      fbLatency = 4;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      checkOutput("midscan read before reset", val_t'(read), val_t'(1));
      #2;
      reset = 1'b0;
      #1;
      checkOutput("midscan read dropped", val_t'(read), val_t'(0));
      checkOutput("midscan busy dropped", val_t'(busy), val_t'(0));
      checkOutput("midscan win_valid low", val_t'(win_valid), val_t'(0));
      checkOutput("midscan no done", val_t'(done), val_t'(0));
      repeat (2) @(negedge clk);
      reset     = 1'b1;
      fbLatency = 0;
      @(negedge clk);
      applyStimulus(80, 1'b0, "frameE");

      $display("[TB] randomized frames");
      for (int f = 0; f < 3; f++) begin
         fbHold = int'($urandom_range(1, 3));
         applyStimulus(int'($urandom_range(30, 100)), 1'b0, $sformatf("rand%0d", f));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
